// File: rtl/karatsuba_pkg.sv
// Shared helpers for the pipelined Karatsuba multiplier: latency, half width
// and the operand-width legality test used at elaboration.
package karatsuba_pkg;

  function automatic int kara_latency(input int mult_stages);
    return mult_stages + 3;
  endfunction

  function automatic int half_w(input int width);
    return width / 2;
  endfunction

  function automatic bit width_ok(input int width);
    return (width >= 4) && (width % 2 == 0);
  endfunction

endpackage

// File: rtl/mult_karatsuba_pipe_mult.sv
// Generic unsigned IN_W x IN_W multiplier: registered operands, then the
// product travels through STAGES registers; everything advances on en.
module mult_pipe_u #(
  parameter int IN_W   = 32,
  parameter int STAGES = 2
) (
  input  logic                clk,
  input  logic                en,
  input  logic [IN_W-1:0]     a_i,
  input  logic [IN_W-1:0]     b_i,
  output logic [2*IN_W-1:0]   p_o
);

  logic [IN_W-1:0]   a_q, b_q;
  logic [2*IN_W-1:0] p_q [STAGES];

  // NOTE: pure data pipeline with no reset; validity is tracked by the parent,
  // so stale contents here are never observed.
  always_ff @(posedge clk) begin
    if (en) begin
      a_q    <= a_i;
      b_q    <= b_i;
      p_q[0] <= {{IN_W{1'b0}}, a_q} * {{IN_W{1'b0}}, b_q};
      for (int i = 1; i < STAGES; i++) begin
        p_q[i] <= p_q[i-1];
      end
    end
  end

  assign p_o = p_q[STAGES-1];

endmodule

// File: rtl/mult_karatsuba_pipe.sv
// Fully pipelined single-level Karatsuba multiplier with joined A/B stream
// inputs, a tag carried alongside each pair, and whole-pipeline backpressure.
module mult_karatsuba_pipe
  import karatsuba_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int MULT_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     input_a_tdata,
  input  logic                 input_a_tvalid,
  output logic                 input_a_tready,
  input  logic [TAG_W-1:0]     input_a_tuser,
  input  logic [WIDTH-1:0]     input_b_tdata,
  input  logic                 input_b_tvalid,
  output logic                 input_b_tready,
  output logic [2*WIDTH-1:0]   output_tdata,
  output logic [TAG_W-1:0]     output_tuser,
  output logic                 output_tvalid,
  input  logic                 output_tready,
  output logic                 busy
);

  localparam int H   = half_w(WIDTH);
  localparam int LAT = kara_latency(MULT_STAGES);
  localparam int PW  = 2 * WIDTH;

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("mult_karatsuba_pipe: WIDTH must be even and >= 4");
  end
  if (MULT_STAGES < 1) begin : g_bad_stages
    $error("mult_karatsuba_pipe: MULT_STAGES must be >= 1");
  end

  logic en, xfer;
  assign en   = !output_tvalid || output_tready;
  assign xfer = input_a_tvalid && input_b_tvalid && en;

  // Joined handshake; both readies are held low while reset is asserted.
  assign input_a_tready = rst && input_b_tvalid && en;
  assign input_b_tready = rst && input_a_tvalid && en;

  // valid_q[0] is the capture stage, valid_q[LAT-1] the mid-term stage.
  logic [LAT-1:0]   valid_q;
  logic [TAG_W-1:0] tag_q [LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) valid_q <= '0;
    else if (en) valid_q <= {valid_q[LAT-2:0], xfer};
  end

  always_ff @(posedge clk) begin
    if (en) begin
      tag_q[0] <= input_a_tuser;
      for (int i = 1; i < LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  logic [H-1:0] ah_q, al_q, bh_q, bl_q;
  logic [H:0]   sa_q, sb_q;

  always_ff @(posedge clk) begin
    if (en) begin
      ah_q <= input_a_tdata[WIDTH-1:H];
      al_q <= input_a_tdata[H-1:0];
      bh_q <= input_b_tdata[WIDTH-1:H];
      bl_q <= input_b_tdata[H-1:0];
      sa_q <= {1'b0, input_a_tdata[WIDTH-1:H]} + {1'b0, input_a_tdata[H-1:0]};
      sb_q <= {1'b0, input_b_tdata[WIDTH-1:H]} + {1'b0, input_b_tdata[H-1:0]};
    end
  end

  logic [2*H-1:0] p_hi, p_lo;
  logic [2*H+1:0] p_mid;

  mult_pipe_u #(.IN_W(H),   .STAGES(MULT_STAGES)) u_hi
    (.clk(clk), .en(en), .a_i(ah_q), .b_i(bh_q), .p_o(p_hi));
  mult_pipe_u #(.IN_W(H),   .STAGES(MULT_STAGES)) u_lo
    (.clk(clk), .en(en), .a_i(al_q), .b_i(bl_q), .p_o(p_lo));
  mult_pipe_u #(.IN_W(H+1), .STAGES(MULT_STAGES)) u_mid
    (.clk(clk), .en(en), .a_i(sa_q), .b_i(sb_q), .p_o(p_mid));

  logic [2*H-1:0] p_hi_q, p_lo_q;
  logic [2*H+1:0] mid_q;

  // The cross term is non-negative, so unsigned subtraction cannot wrap.
  always_ff @(posedge clk) begin
    if (en) begin
      p_hi_q <= p_hi;
      p_lo_q <= p_lo;
      mid_q  <= p_mid - {2'b00, p_hi} - {2'b00, p_lo};
    end
  end

  logic [PW-1:0] sum_d;
  assign sum_d = (PW'(p_hi_q) << WIDTH) + (PW'(mid_q) << H) + PW'(p_lo_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      output_tvalid <= 1'b0;
      output_tdata  <= '0;
      output_tuser  <= '0;
    end else if (en) begin
      output_tvalid <= valid_q[LAT-1];
      output_tdata  <= sum_d;
      output_tuser  <= tag_q[LAT-1];
    end
  end

  assign busy = (|valid_q) || output_tvalid;

endmodule

// File: tb/tb_mult_karatsuba_pipe.sv
// Self-checking bench: directed corner products, random streaming and
// backpressure against a plain-multiply scoreboard, async reset, and a sweep.
module tb_mult_karatsuba_pipe;

  localparam int W  = 64;
  localparam int MS = 2;
  localparam int TW = 4;
  localparam int L  = MS + 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, s_rst;
  logic [W-1:0]    a_data, b_data;
  logic            a_valid, b_valid, a_ready, b_ready;
  logic [TW-1:0]   a_user, o_user;
  logic [2*W-1:0]  o_data;
  logic            o_valid, o_ready, busy;

  mult_karatsuba_pipe #(.WIDTH(W), .MULT_STAGES(MS), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .input_a_tdata(a_data), .input_a_tvalid(a_valid), .input_a_tready(a_ready),
    .input_a_tuser(a_user),
    .input_b_tdata(b_data), .input_b_tvalid(b_valid), .input_b_tready(b_ready),
    .output_tdata(o_data), .output_tuser(o_user), .output_tvalid(o_valid),
    .output_tready(o_ready), .busy(busy)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference scoreboard for the main instance: product of the accepted pair.
  typedef struct packed {
    logic [2*W-1:0] prod;
    logic [TW-1:0]  tag;
  } exp_t;

  exp_t           sb[$];
  int             n_in = 0, n_out = 0;
  logic           stalled_q = 1'b0;
  logic [2*W-1:0] held_data;
  logic [TW-1:0]  held_tag;

  always @(negedge clk) begin
    logic [2*W-1:0] ax, bx;
    exp_t e;
    if (!rst) begin
      sb.delete();
      stalled_q = 1'b0;
    end else begin
      if (stalled_q) begin
        check("hold_valid", o_valid, 1);
        check("hold_data", o_data, held_data);
        check("hold_tag", o_user, held_tag);
      end
      if (o_valid && !o_ready) begin
        check("a_ready_in_stall", a_ready, 0);
        check("b_ready_in_stall", b_ready, 0);
      end
      if (a_valid && a_ready && b_valid && b_ready) begin
        ax = {{W{1'b0}}, a_data};
        bx = {{W{1'b0}}, b_data};
        sb.push_back('{prod: ax * bx, tag: a_user});
        n_in++;
      end
      if (o_valid && o_ready) begin
        n_out++;
        if (sb.size() == 0) check("spurious_out", o_valid, 0);
        else begin
          e = sb.pop_front();
          check("prod", o_data, e.prod);
          check("tag", o_user, e.tag);
        end
      end
      stalled_q = o_valid && !o_ready;
      held_data = o_data;
      held_tag  = o_user;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  // Present a pair and return just after the edge that accepts it.
  task automatic drive_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [TW-1:0] t, output int waits);
    bit hs = 1'b0;
    a_data = a; b_data = b; a_user = t;
    a_valid = 1'b1; b_valid = 1'b1;
    waits = 0;
    while (!hs && waits < 100) begin
      @(negedge clk);
      hs = a_ready && b_ready;
      tick();
      if (!hs) waits++;
    end
    if (!hs) check("xfer_timeout", hs, 1);
  endtask

  task automatic send_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] t,
                          input logic [2*W-1:0] expected, input string name);
    int w, n;
    drive_pair(a, b, t, w);
    idle();
    n = 0;
    while (!o_valid && n < 40) begin
      tick();
      n++;
    end
    check({name, "_latency"}, n, L);
    check({name, "_data"}, o_data, expected);
    check({name, "_tag"}, o_user, t);
    tick();
  endtask

  // Parameter sweep: independent instances with tready tied high.
  for (genvar g = 0; g < 6; g++) begin : g_sw
    localparam int SWD = 8 << (2 * (g / 2));
    localparam int SMS = (g % 2 == 1) ? 3 : 1;
    localparam int SL  = SMS + 3;
    localparam int PW  = 2 * SWD;
    localparam int N   = (SWD == 8) ? 65536 : 300;

    logic [SWD-1:0] s_a, s_b;
    logic           s_av, s_bv, s_ar, s_br, s_ov, s_busy;
    logic [PW-1:0]  s_out;
    logic [TW-1:0]  s_user;
    logic [PW-1:0]  q[$];
    int             s_nout = 0;
    bit             done = 1'b0;

    mult_karatsuba_pipe #(.WIDTH(SWD), .MULT_STAGES(SMS), .TAG_W(TW)) u_sw (
      .clk(clk), .rst(s_rst),
      .input_a_tdata(s_a), .input_a_tvalid(s_av), .input_a_tready(s_ar),
      .input_a_tuser('0),
      .input_b_tdata(s_b), .input_b_tvalid(s_bv), .input_b_tready(s_br),
      .output_tdata(s_out), .output_tuser(s_user), .output_tvalid(s_ov),
      .output_tready(1'b1), .busy(s_busy)
    );

    always @(negedge clk) begin
      logic [PW-1:0] e;
      if (s_rst) begin
        if (s_av && s_ar && s_bv && s_br) q.push_back(PW'(s_a) * PW'(s_b));
        if (s_ov) begin
          s_nout++;
          if (q.size() == 0) check("sweep_spurious", s_ov, 0);
          else begin
            e = q.pop_front();
            check("sweep_prod", s_out, e);
          end
        end
      end
    end

    initial begin
      logic [127:0] r;
      logic [15:0]  iv;
      bit hs;
      int n;
      s_av = 1'b0; s_bv = 1'b0; s_a = '0; s_b = '0;
      wait (s_rst);
      tick();
      r = {$urandom, $urandom, $urandom, $urandom};
      s_a = r[SWD-1:0];
      s_b = r[127 -: SWD];
      s_av = 1'b1; s_bv = 1'b1;
      @(negedge clk);
      hs = s_ar && s_br;
      tick();
      s_av = 1'b0; s_bv = 1'b0;
      check("sweep_first_xfer", hs, 1);
      n = 0;
      while (!s_ov && n < 40) begin
        tick();
        n++;
      end
      check("sweep_latency", n, SL);
      s_av = 1'b1; s_bv = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (SWD == 8) begin
          iv  = 16'(i);
          s_a = SWD'(iv[15:8]);
          s_b = SWD'(iv[7:0]);
        end else begin
          r   = {$urandom, $urandom, $urandom, $urandom};
          s_a = r[SWD-1:0];
          r   = {$urandom, $urandom, $urandom, $urandom};
          s_b = r[SWD-1:0];
        end
        tick();
      end
      s_av = 1'b0; s_bv = 1'b0;
      repeat (SL + 5) tick();
      check("sweep_count", s_nout, N + 1);
      done = 1'b1;
    end
  end

  initial begin
    int w, stalls, k, in0, out0;
    logic [W-1:0] rb;
    bit all_done;

    rst = 1'b0; s_rst = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1;
    a_data = '1; b_data = '1; a_user = '1;
    o_ready = 1'b0;
    #12;
    check("rst_tvalid", o_valid, 0);
    check("rst_tdata", o_data, 0);
    check("rst_tuser", o_user, 0);
    check("rst_busy", busy, 0);
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    idle();
    o_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1; s_rst = 1'b1;
    tick();

    send_one(64'h8000_0000_8000_0000, 64'h8000_0000_8000_0000, 4'h3,
             128'h40000000_80000000_40000000_00000000, "carry");
    send_one(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'hA,
             128'hFFFFFFFF_FFFFFFFE_00000000_00000001, "all_ones");
    rb = {$urandom, $urandom};
    send_one(64'd0, rb, 4'h5, 128'd0, "zero");
    rb = {$urandom, $urandom};
    send_one(64'd1, rb, 4'hC, {64'd0, rb}, "one");

    stalls = 0;
    out0 = n_out;
    for (int i = 0; i < 1000; i++) begin
      drive_pair({$urandom, $urandom}, {$urandom, $urandom}, TW'(i % 16), w);
      stalls += w;
    end
    idle();
    k = 0;
    while (sb.size() != 0 && k < 50) begin
      tick();
      k++;
    end
    check("stream_stalls", stalls, 0);
    check("stream_drained", sb.size(), 0);
    check("stream_count", n_out - out0, 1000);

    in0 = n_in; out0 = n_out;
    for (int c = 0; c < 1500; c++) begin
      o_ready = 1'($urandom_range(0, 1));
      a_valid = 1'($urandom_range(0, 1));
      b_valid = 1'($urandom_range(0, 1));
      a_data  = {$urandom, $urandom};
      b_data  = {$urandom, $urandom};
      a_user  = TW'($urandom);
      tick();
    end
    idle();
    o_ready = 1'b1;
    k = 0;
    while (sb.size() != 0 && k < 50) begin
      tick();
      k++;
    end
    check("bp_drained", sb.size(), 0);
    check("bp_in_eq_out", n_out - out0, n_in - in0);

    drive_pair(64'd11, 64'd12, 4'h1, w);
    drive_pair(64'd13, 64'd14, 4'h2, w);
    drive_pair(64'd15, 64'd16, 4'h3, w);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_tvalid", o_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_a_ready", a_ready, 0);
    check("midrst_b_ready", b_ready, 0);
    @(negedge clk);
    idle();
    tick();
    rst = 1'b1;
    tick();
    send_one(64'd3, 64'd5, 4'h9, 128'd15, "after_rst");
    repeat (10) tick();
    check("after_rst_busy", busy, 0);
    check("after_rst_sb", sb.size(), 0);

    k = 0;
    all_done = 1'b0;
    while (!all_done && k < 70000) begin
      all_done = g_sw[0].done && g_sw[1].done && g_sw[2].done &&
                 g_sw[3].done && g_sw[4].done && g_sw[5].done;
      if (!all_done) tick();
      k++;
    end
    check("sweep_done", all_done, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
